fp_scoreboard: RTL and testbench

FP_SCOREBOARD -- requirements
Module: fp_scoreboard

---
 rtl/fp_wire.sv | 38 +++
 rtl/fp_scb_fifo.sv | 79 +++++++
 rtl/fp_scoreboard.sv | 138 +++++++++++++
 tb/tb_fp_scoreboard.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_wire.sv
`default_nettype none
// ============================================================================
//  Module      : fp_wire (package)
//  Description : Shared types and constants for the FP result scoreboard:
//                first-error code, scoreboard state, canonical quiet-NaN
//                patterns and the packed expected-result entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_wire;

    // First-error code reported on err_code.
    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_MISMATCH  = 2'd1,
        ERR_UNDERFLOW = 2'd2,
        ERR_OVERFLOW  = 2'd3
    } err_code_e;

    // Scoreboard state: RUN until the first error, then HALT until reset.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } scb_state_e;

    // Canonical quiet NaNs produced by the FP unit.
    localparam logic [31:0] c_qnan_single = 32'h7FC0_0000;
    localparam logic [63:0] c_qnan_double = 64'h7FF8_0000_0000_0000;

    // One expected-result entry as stored in the FIFO.
    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic [1:0]  fmt;    // 0 = single, nonzero = double
        logic        f2i;    // fcvt_f2i: no NaN relaxation
    } exp_entry_t;

endpackage : fp_wire
`default_nettype wire

// File: rtl/fp_scb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fp_scb_fifo
//  Description : Expected-entry FIFO for the FP scoreboard. Head is exposed
//                combinationally so the caller can compare and pop on the
//                same edge. Storage is not cleared by reset.
//  Ports       : clock, reset (sync, active-low)
//                push, push_data  - write at tail (ignored when full)
//                pop              - advance head (ignored when empty)
//                full, empty      - occupancy status
//                head             - entry at the read pointer
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_scb_fifo
    import fp_wire::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  exp_entry_t push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output exp_entry_t head
);

    localparam int c_ptr_w = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fp_scb_fifo: DEPTH must be a power of two in 2..64");
        end
    endgenerate

    exp_entry_t         r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == DEPTH[c_ptr_w:0]);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : fp_scb_fifo
`default_nettype wire

// File: rtl/fp_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : fp_scoreboard
//  Description : In-order scoreboard for an FP unit. Expected results are
//                queued; each DUT result is compared against the queue head
//                with canonical-NaN relaxation, pass/fail are counted, and
//                the first error halts the scoreboard until reset.
//  Ports       : clock, reset (sync, active-low)
//                exp_valid/exp_result/exp_flags/exp_fmt/exp_f2i - push side
//                exp_ready        - push accepted this cycle
//                dut_ready/dut_result/dut_flags - FP unit result
//                pass_count, fail_count - saturating counters
//                error, err_code, err_result_diff, err_flags_diff - first error
//                empty            - expected FIFO empty
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_scoreboard
    import fp_wire::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exp_valid,
    input  logic [63:0] exp_result,
    input  logic [4:0]  exp_flags,
    input  logic [1:0]  exp_fmt,
    input  logic        exp_f2i,
    output logic        exp_ready,
    input  logic        dut_ready,
    input  logic [63:0] dut_result,
    input  logic [4:0]  dut_flags,
    output logic [31:0] pass_count,
    output logic [31:0] fail_count,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [63:0] err_result_diff,
    output logic [4:0]  err_flags_diff,
    output logic        empty
);

    scb_state_e  r_state;
    err_code_e   r_err_code;

    exp_entry_t  w_push_data;
    exp_entry_t  w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_run;
    logic        w_push;
    logic        w_pop;
    logic        w_underflow;
    logic        w_overflow;
    logic [63:0] w_diff;
    logic [4:0]  w_flags_diff;
    logic        w_mismatch;

    assign w_run       = (r_state == RUN);
    assign exp_ready   = w_run && !w_full;
    assign empty       = w_empty;
    assign w_push      = exp_valid && exp_ready;
    assign w_pop       = w_run && dut_ready && !w_empty;
    // No bypass: a pop against an empty FIFO is an underflow even if a push
    // lands on the same edge.
    assign w_underflow = w_run && dut_ready && w_empty;
    assign w_overflow  = w_run && exp_valid && w_full;

    assign w_push_data = '{result: exp_result, flags: exp_flags,
                           fmt: exp_fmt, f2i: exp_f2i};

    fp_scb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    // When the DUT returns a canonical NaN (and the op is not a float-to-int
    // conversion) only the exponent and quiet bit have to agree: sign and
    // payload of the expected NaN are don't-care.
    always_comb begin
        w_diff = dut_result ^ w_head.result;
        if (!w_head.f2i && w_head.fmt == 2'd0 && dut_result[31:0] == c_qnan_single) begin
            w_diff = {32'h0, 1'b0, dut_result[30:22] ^ w_head.result[30:22], 22'h0};
        end else if (!w_head.f2i && w_head.fmt != 2'd0 && dut_result == c_qnan_double) begin
            w_diff = {1'b0, dut_result[62:51] ^ w_head.result[62:51], 51'h0};
        end
    end

    assign w_flags_diff = dut_flags ^ w_head.flags;
    assign w_mismatch   = w_pop && ((w_diff != '0) || (w_flags_diff != '0));

    // In HALT nothing changes until reset. If several errors occur on one
    // edge, a mismatch is reported first so the captured diffs are useful.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state         <= RUN;
            pass_count      <= '0;
            fail_count      <= '0;
            error           <= 1'b0;
            r_err_code      <= ERR_NONE;
            err_result_diff <= '0;
            err_flags_diff  <= '0;
        end else if (r_state == RUN) begin
            if (w_pop && !w_mismatch && pass_count != 32'hFFFF_FFFF) begin
                pass_count <= pass_count + 32'd1;
            end
            if (w_mismatch && fail_count != 32'hFFFF_FFFF) begin
                fail_count <= fail_count + 32'd1;
            end
            if (w_mismatch) begin
                r_state         <= HALT;
                error           <= 1'b1;
                r_err_code      <= ERR_MISMATCH;
                err_result_diff <= w_diff;
                err_flags_diff  <= w_flags_diff;
            end else if (w_underflow) begin
                r_state    <= HALT;
                error      <= 1'b1;
                r_err_code <= ERR_UNDERFLOW;
            end else if (w_overflow) begin
                r_state    <= HALT;
                error      <= 1'b1;
                r_err_code <= ERR_OVERFLOW;
            end
        end
    end

    assign err_code = r_err_code;

endmodule : fp_scoreboard
`default_nettype wire

// File: tb/tb_fp_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_scoreboard
//  Description : Directed self-checking bench for fp_scoreboard (DEPTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_scoreboard;
    import fp_wire::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exp_valid = 1'b0;
    logic [63:0] exp_result = '0;
    logic [4:0]  exp_flags = '0;
    logic [1:0]  exp_fmt = '0;
    logic        exp_f2i = 1'b0;
    logic        exp_ready;
    logic        dut_ready = 1'b0;
    logic [63:0] dut_result = '0;
    logic [4:0]  dut_flags = '0;
    logic [31:0] pass_count;
    logic [31:0] fail_count;
    logic        error;
    logic [1:0]  err_code;
    logic [63:0] err_result_diff;
    logic [4:0]  err_flags_diff;
    logic        empty;

    int passed = 0;
    int total  = 0;

    localparam logic [63:0] c_one_d = 64'h3FF0_0000_0000_0000;
    localparam exp_entry_t  c_none  = '0;

    fp_scoreboard #(.DEPTH(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .exp_valid       (exp_valid),
        .exp_result      (exp_result),
        .exp_flags       (exp_flags),
        .exp_fmt         (exp_fmt),
        .exp_f2i         (exp_f2i),
        .exp_ready       (exp_ready),
        .dut_ready       (dut_ready),
        .dut_result      (dut_result),
        .dut_flags       (dut_flags),
        .pass_count      (pass_count),
        .fail_count      (fail_count),
        .error           (error),
        .err_code        (err_code),
        .err_result_diff (err_result_diff),
        .err_flags_diff  (err_flags_diff),
        .empty           (empty)
    );

    always #5 clock = ~clock;

    function automatic exp_entry_t mk(input logic [63:0] r, input logic [4:0] f,
                                      input logic [1:0] fmt, input logic f2i);
        exp_entry_t e;
        e.result = r;
        e.flags  = f;
        e.fmt    = fmt;
        e.f2i    = f2i;
        return e;
    endfunction

    // One clock: drive push/pop, pass the rising edge, settle 1 time unit.
    task automatic cycle(input logic pv, input exp_entry_t e, input logic dr,
                         input logic [63:0] dres, input logic [4:0] dfl);
        exp_valid  = pv;
        exp_result = e.result;
        exp_flags  = e.flags;
        exp_fmt    = e.fmt;
        exp_f2i    = e.f2i;
        dut_ready  = dr;
        dut_result = dres;
        dut_flags  = dfl;
        @(posedge clock);
        #1;
        exp_valid = 1'b0;
        dut_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle(1'b0, c_none, 1'b0, 64'h0, 5'h0);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pass_count !== 32'd0) $display("FAIL reset_pass: got %0d want 0", pass_count); else passed++;
        total++; if (fail_count !== 32'd0) $display("FAIL reset_fail: got %0d want 0", fail_count); else passed++;
        total++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else passed++;
        total++; if (err_code !== 2'd0) $display("FAIL reset_err_code: got %0d want 0", err_code); else passed++;
        total++; if (err_result_diff !== 64'h0) $display("FAIL reset_rdiff: got %h want 0", err_result_diff); else passed++;
        total++; if (err_flags_diff !== 5'h0) $display("FAIL reset_fdiff: got %h want 0", err_flags_diff); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else passed++;
        total++; if (exp_ready !== 1'b1) $display("FAIL reset_exp_ready: got %b want 1", exp_ready); else passed++;
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(c_one_d, 5'h0, 2'd1, 1'b0), 1'b0, 64'h0, 5'h0);
        total++; if (empty !== 1'b0) $display("FAIL basic_not_empty: got %b want 0", empty); else passed++;
        for (int i = 0; i < 3; i++) cycle(1'b0, c_none, 1'b1, c_one_d, 5'h0);
        total++; if (pass_count !== 32'd3) $display("FAIL basic_pass: got %0d want 3", pass_count); else passed++;
        total++; if (fail_count !== 32'd0) $display("FAIL basic_fail: got %0d want 0", fail_count); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL basic_empty: got %b want 1", empty); else passed++;
        total++; if (error !== 1'b0) $display("FAIL basic_error: got %b want 0", error); else passed++;
    endtask

    task automatic test_nan_relax();
        do_reset();
        // Double canonical NaN vs expected NaN with different sign/payload.
        cycle(1'b1, mk(64'hFFF8_0000_0000_0ABC, 5'h0, 2'd1, 1'b0), 1'b0, 64'h0, 5'h0);
        cycle(1'b0, c_none, 1'b1, 64'h7FF8_0000_0000_0000, 5'h0);
        total++; if (pass_count !== 32'd1) $display("FAIL nan_double_pass: got %0d want 1", pass_count); else passed++;
        // Single NaN relaxation.
        cycle(1'b1, mk(64'h0000_0000_7FC0_0001, 5'h0, 2'd0, 1'b0), 1'b0, 64'h0, 5'h0);
        cycle(1'b0, c_none, 1'b1, 64'h0000_0000_7FC0_0000, 5'h0);
        total++; if (pass_count !== 32'd2) $display("FAIL nan_single_pass: got %0d want 2", pass_count); else passed++;
        total++; if (error !== 1'b0) $display("FAIL nan_single_error: got %b want 0", error); else passed++;
        // Same with f2i: exact compare required.
        cycle(1'b1, mk(64'h0000_0000_7FC0_0001, 5'h0, 2'd0, 1'b1), 1'b0, 64'h0, 5'h0);
        cycle(1'b0, c_none, 1'b1, 64'h0000_0000_7FC0_0000, 5'h0);
        total++; if (fail_count !== 32'd1) $display("FAIL f2i_fail: got %0d want 1", fail_count); else passed++;
        total++; if (err_code !== 2'd1) $display("FAIL f2i_err_code: got %0d want 1", err_code); else passed++;
        total++; if (err_result_diff !== 64'h1) $display("FAIL f2i_rdiff: got %h want 1", err_result_diff); else passed++;
        total++; if (pass_count !== 32'd2) $display("FAIL f2i_pass_keep: got %0d want 2", pass_count); else passed++;
        // HALT freezes everything.
        cycle(1'b1, mk(c_one_d, 5'h0, 2'd1, 1'b0), 1'b1, 64'h5, 5'h3);
        total++; if (empty !== 1'b1) $display("FAIL halt_push_ignored: got %b want 1", empty); else passed++;
        total++; if (exp_ready !== 1'b0) $display("FAIL halt_exp_ready: got %b want 0", exp_ready); else passed++;
        total++; if (fail_count !== 32'd1) $display("FAIL halt_fail_frozen: got %0d want 1", fail_count); else passed++;
        total++; if (err_code !== 2'd1) $display("FAIL halt_code_frozen: got %0d want 1", err_code); else passed++;
    endtask

    task automatic test_underflow();
        do_reset();
        cycle(1'b1, mk(c_one_d, 5'h0, 2'd1, 1'b0), 1'b1, c_one_d, 5'h0);
        total++; if (error !== 1'b1) $display("FAIL uf_error: got %b want 1", error); else passed++;
        total++; if (err_code !== 2'd2) $display("FAIL uf_err_code: got %0d want 2", err_code); else passed++;
        total++; if (empty !== 1'b0) $display("FAIL uf_push_kept: got %b want 0", empty); else passed++;
        total++; if (pass_count !== 32'd0) $display("FAIL uf_pass: got %0d want 0", pass_count); else passed++;
        total++; if (exp_ready !== 1'b0) $display("FAIL uf_exp_ready: got %b want 0", exp_ready); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, mk(c_one_d, 5'h0, 2'd1, 1'b0), 1'b0, 64'h0, 5'h0);
        total++; if (exp_ready !== 1'b0) $display("FAIL of_full_ready: got %b want 0", exp_ready); else passed++;
        total++; if (error !== 1'b0) $display("FAIL of_full_error: got %b want 0", error); else passed++;
        cycle(1'b1, mk(c_one_d, 5'h0, 2'd1, 1'b0), 1'b0, 64'h0, 5'h0);
        total++; if (err_code !== 2'd3) $display("FAIL of_err_code: got %0d want 3", err_code); else passed++;
        total++; if (error !== 1'b1) $display("FAIL of_error: got %b want 1", error); else passed++;
        total++; if (pass_count !== 32'd0) $display("FAIL of_pass: got %0d want 0", pass_count); else passed++;
        // Push and pop together while full is still an overflow.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, mk(c_one_d, 5'h0, 2'd1, 1'b0), 1'b0, 64'h0, 5'h0);
        cycle(1'b1, mk(c_one_d, 5'h0, 2'd1, 1'b0), 1'b1, c_one_d, 5'h0);
        total++; if (err_code !== 2'd3) $display("FAIL of_pushpop_code: got %0d want 3", err_code); else passed++;
    endtask

    task automatic test_back_to_back();
        exp_entry_t q[$];
        exp_entry_t e;
        exp_entry_t h;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            e = mk(c_one_d ^ (64'(i) << 8), 5'(i), 2'd1, 1'b0);
            if (i < 4) begin
                q.push_back(e);
                cycle(1'b1, e, 1'b0, 64'h0, 5'h0);
            end else begin
                h = q.pop_front();
                q.push_back(e);
                cycle(1'b1, e, 1'b1, h.result, h.flags);
            end
        end
        for (int i = 0; i < 4; i++) begin
            h = q.pop_front();
            cycle(1'b0, c_none, 1'b1, h.result, h.flags);
        end
        total++; if (pass_count !== 32'd20) $display("FAIL wrap_pass: got %0d want 20", pass_count); else passed++;
        total++; if (fail_count !== 32'd0) $display("FAIL wrap_fail: got %0d want 0", fail_count); else passed++;
        total++; if (error !== 1'b0) $display("FAIL wrap_error: got %b want 0", error); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty); else passed++;
        // Reset in mid-stream.
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(c_one_d, 5'h0, 2'd1, 1'b0), 1'b0, 64'h0, 5'h0);
        cycle(1'b0, c_none, 1'b1, c_one_d, 5'h0);
        do_reset();
        total++; if (pass_count !== 32'd0) $display("FAIL mid_reset_pass: got %0d want 0", pass_count); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL mid_reset_empty: got %b want 1", empty); else passed++;
        total++; if (exp_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b want 1", exp_ready); else passed++;
        total++; if (err_code !== 2'd0) $display("FAIL mid_reset_code: got %0d want 0", err_code); else passed++;
    endtask

    task automatic test_flags_only();
        do_reset();
        cycle(1'b1, mk(c_one_d, 5'b00001, 2'd1, 1'b0), 1'b0, 64'h0, 5'h0);
        cycle(1'b0, c_none, 1'b1, c_one_d, 5'b00000);
        total++; if (err_flags_diff !== 5'b00001) $display("FAIL flags_fdiff: got %b want 00001", err_flags_diff); else passed++;
        total++; if (err_result_diff !== 64'h0) $display("FAIL flags_rdiff: got %h want 0", err_result_diff); else passed++;
        total++; if (err_code !== 2'd1) $display("FAIL flags_code: got %0d want 1", err_code); else passed++;
        total++; if (fail_count !== 32'd1) $display("FAIL flags_fail: got %0d want 1", fail_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nan_relax();
        test_underflow();
        test_overflow();
        test_back_to_back();
        test_flags_only();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_fp_scoreboard
`default_nettype wire
